// File: rtl/instruction_sequencer.sv
// Instruction sequencer: replays a loaded program word by word over the start/done handshake.
// Optional macro SEQ_TIMEOUT_EN adds an EXEC watchdog that aborts into HALT and sets error.
module instruction_sequencer #(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [11:0]   prog_data,
    input  logic [AW-1:0] last_addr,
    input  logic          run,
    input  logic          abort,
    input  logic          proc_done,
    output logic [11:0]   machine_code,
    output logic          start,
    output logic          busy,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [7:0]    instr_count,
    output logic          error
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t        state;
    state_t        state_next;
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] last_q;
    logic          idle_like;
    logic          accept;
    logic          done_ok;
    logic          timeout;

    assign idle_like = (state == IDLE) || (state == HALT);
    assign accept    = idle_like && run;
    assign done_ok   = (state == EXEC) && proc_done;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, HALT: if (run) state_next = FETCH;
            FETCH:      state_next = abort ? HALT : EXEC;
            EXEC: begin
                if (abort || timeout)
                    state_next = HALT;
                else if (proc_done)
                    state_next = (pc == last_q) ? HALT : FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Program memory is deliberately outside reset so it survives a mid-run reset
    always_ff @(posedge clock) begin
        if (prog_we && idle_like)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            machine_code <= '0;
            start        <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            pc           <= '0;
            last_q       <= '0;
            instr_count  <= '0;
        end else begin
            start  <= (state_next == EXEC);
            busy   <= (state_next == FETCH) || (state_next == EXEC);
            halted <= (state_next == HALT);
            if (accept) begin
                pc          <= '0;
                last_q      <= last_addr;
                instr_count <= '0;
            end
            if (state == FETCH && !abort)
                machine_code <= mem[pc];
            if (done_ok && instr_count != 8'hFF)
                instr_count <= instr_count + 8'd1;
            if (done_ok && !abort && pc != last_q)
                pc <= pc + 1'b1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;

    assign timeout = (state == EXEC) && !proc_done
                   && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcnt  <= '0;
            error <= 1'b0;
        end else begin
            if (state != EXEC)
                tcnt <= '0;
            else if (!proc_done)
                tcnt <= tcnt + 1'b1;
            if (accept)
                error <= 1'b0;
            else if (timeout)
                error <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed plan cases plus random programs,
// checked against a per-instruction expectation built from a mirror of the program.
module tb_instruction_sequencer;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [11:0]   prog_data;
    logic [AW-1:0] last_addr;
    logic          run;
    logic          abort;
    logic          proc_done;
    logic [11:0]   machine_code;
    logic          start;
    logic          busy;
    logic          halted;
    logic [AW-1:0] pc;
    logic [7:0]    instr_count;
    logic          error;

    logic [11:0]   model [16];
    int            total = 0;
    int            bad   = 0;

    instruction_sequencer #(
        .DEPTH(16), .AW(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .last_addr(last_addr), .run(run), .abort(abort),
        .proc_done(proc_done), .machine_code(machine_code),
        .start(start), .busy(busy), .halted(halted), .pc(pc),
        .instr_count(instr_count), .error(error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input logic [11:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(negedge clock);
        prog_we   = 1'b0;
        model[a]  = d;
    endtask

    // Runs one program; ab_k selects the instruction to abort (-1 none)
    task automatic run_prog(input int last, input int ab_k, input bit both,
                            input bit we_exec, input bit wr_run,
                            input int fixed_d);
        logic [11:0] w;
        int d;
        run       = 1'b1;
        last_addr = AW'(last);
        if (wr_run) begin
            w         = 12'($urandom);
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = w;
            model[0]  = w;
        end
        @(negedge clock);
        run     = 1'b0;
        prog_we = 1'b0;
        chk("fetch_start", 32'(start), 0);
        chk("fetch_busy", 32'(busy), 1);
        chk("fetch_pc", 32'(pc), 0);
        chk("fetch_cnt", 32'(instr_count), 0);
        chk("fetch_err", 32'(error), 0);
        @(negedge clock);
        for (int k = 0; k <= last; k++) begin
            chk("exec_start", 32'(start), 1);
            chk("exec_mc", 32'(machine_code), 32'(model[k]));
            chk("exec_pc", 32'(pc), k);
            chk("exec_cnt", 32'(instr_count), k);
            d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 4));
            for (int i = 0; i < d; i++) begin
                @(negedge clock);
                chk("hold_start", 32'(start), 1);
                chk("hold_mc", 32'(machine_code), 32'(model[k]));
            end
            if (k == ab_k) begin
                abort     = 1'b1;
                proc_done = both;
            end else begin
                proc_done = 1'b1;
            end
            if (we_exec) begin
                prog_we   = 1'b1;
                prog_addr = AW'(1);
                prog_data = ~model[1];
            end
            @(negedge clock);
            abort     = 1'b0;
            proc_done = 1'b0;
            prog_we   = 1'b0;
            if (k == ab_k) begin
                chk("abort_halted", 32'(halted), 1);
                chk("abort_start", 32'(start), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_pc", 32'(pc), k);
                chk("abort_cnt", 32'(instr_count), k + int'(both));
                return;
            end
            if (k == last) begin
                chk("end_halted", 32'(halted), 1);
                chk("end_start", 32'(start), 0);
                chk("end_busy", 32'(busy), 0);
                chk("end_pc", 32'(pc), last);
                chk("end_cnt", 32'(instr_count), last + 1);
                chk("end_mc", 32'(machine_code), 32'(model[last]));
            end else begin
                chk("gap_start", 32'(start), 0);
                chk("gap_pc", 32'(pc), k + 1);
                chk("gap_cnt", 32'(instr_count), k + 1);
                @(negedge clock);
            end
        end
    endtask

    initial begin
        int last;
        int ab;
        logic [7:0] cnt_keep;
        logic [AW-1:0] pc_keep;
        reset     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        last_addr = '0;
        run       = 1'b0;
        abort     = 1'b0;
        proc_done = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (2) @(negedge clock);
        chk("rst_mc", 32'(machine_code), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_cnt", 32'(instr_count), 0);
        chk("rst_err", 32'(error), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 16; i++) load(i, 12'($urandom));
        load(0, 12'h123);
        load(1, 12'h456);
        load(2, 12'h789);
        run_prog(2, -1, 0, 0, 0, 3);

        load(0, 12'hE07);
        run_prog(0, -1, 0, 0, 0, -1);

        for (int i = 0; i < 4; i++) load(i, 12'($urandom));
        run_prog(3, 1, 0, 0, 0, -1);
        run_prog(3, -1, 0, 0, 0, -1);

        run_prog(2, -1, 0, 1, 0, -1);
        run_prog(2, -1, 0, 0, 0, -1);

        run_prog(2, 0, 1, 0, 0, -1);

        run_prog(1, -1, 0, 0, 1, -1);

        // abort and proc_done are ignored in HALT
        cnt_keep  = instr_count;
        pc_keep   = pc;
        abort     = 1'b1;
        proc_done = 1'b1;
        @(negedge clock);
        abort     = 1'b0;
        proc_done = 1'b0;
        chk("halt_ign_halted", 32'(halted), 1);
        chk("halt_ign_busy", 32'(busy), 0);
        chk("halt_ign_cnt", 32'(instr_count), 32'(cnt_keep));
        chk("halt_ign_pc", 32'(pc), 32'(pc_keep));

        // reset in the middle of EXEC
        run       = 1'b1;
        last_addr = AW'(3);
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        chk("pre_rst_start", 32'(start), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_start", 32'(start), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pc", 32'(pc), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_prog(3, -1, 0, 0, 0, -1);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) load(i, 12'($urandom));
            last = int'($urandom_range(0, 15));
            ab   = ($urandom_range(0, 3) == 0)
                 ? int'($urandom_range(0, last)) : -1;
            run_prog(last, ab, 1'($urandom), 0, 0, -1);
        end

`ifdef SEQ_TIMEOUT_EN
        load(0, 12'hABC);
        run       = 1'b1;
        last_addr = '0;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        chk("to_start", 32'(start), 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            chk("to_wait_start", 32'(start), 1);
            chk("to_wait_err", 32'(error), 0);
        end
        @(negedge clock);
        chk("to_halted", 32'(halted), 1);
        chk("to_start_low", 32'(start), 0);
        chk("to_err", 32'(error), 1);
        chk("to_cnt", 32'(instr_count), 0);
        run_prog(0, -1, 0, 0, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Initiator side of the processor's instruction handshake. Holds a small program of 12-bit machine-code words, loaded through a write port. On run, it presents one word at a time on machine_code, holds start high until the processor returns done, then advances to the next word. It sits between the board-level loader/switch logic and the processor, replacing manual machine_code/start drive.

Parameters:
DEPTH, 16, number of 12-bit program words.
AW, 4, address width; must equal clog2(DEPTH).
TIMEOUT_CYCLES, 64, maximum EXEC cycles before abort; used only with SEQ_TIMEOUT_EN.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
prog_we  in  1  program write strobe; honoured only in IDLE or HALT.
prog_addr  in  AW  program write address.
prog_data  in  12  program word {opcode[11:9], p1[8:6], p2[5:3], p3[2:0]}.
last_addr  in  AW  address of the final instruction; sampled when run is accepted.
run  in  1  start/restart execution at address 0 (level, sampled in IDLE/HALT).
abort  in  1  stop execution.
proc_done  in  1  processor instruction-complete indication.
machine_code  out  12  instruction word to processor.
start  out  1  processor enable; high while the instruction executes.
busy  out  1  high in FETCH or EXEC.
halted  out  1  high in HALT.
pc  out  AW  address of the current instruction.
instr_count  out  8  instructions completed since the last run; saturates at 255.
error  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, async): state=IDLE. machine_code=0, start=0, busy=0, halted=0, pc=0, instr_count=0, error=0, latched last_addr=0. Program memory is not reset.
- Memory: DEPTH x 12 with a synchronous write. The read is registered into machine_code in FETCH. A write in IDLE/HALT takes effect at that edge. Writes in FETCH/EXEC are ignored.
- FSM states: IDLE, FETCH, EXEC, HALT. All outputs are registered.
- IDLE: on run=1, go to FETCH with pc=0. Latch last_addr, clear instr_count and error.
- FETCH (1 cycle): load machine_code <= mem[pc], keep start=0, go to EXEC. Latency from run sampled to start=1 is 2 clocks.
- EXEC: start=1. machine_code and pc are held stable.
  - On proc_done=1: start drops on the next edge, and instr_count increments (saturating).
  - If pc==latched last_addr, go to HALT. Otherwise pc<=pc+1 and go to FETCH.
  - start is therefore low for exactly one cycle (FETCH) between instructions.
- HALT: halted=1 and start=0. machine_code and pc keep their last values. run=1 behaves as in IDLE (restart at address 0).
- abort=1 in FETCH or EXEC: go to HALT on the next edge with start=0. abort in IDLE/HALT is ignored.
- abort and proc_done in the same EXEC cycle: the instruction is counted, then go to HALT (abort wins the next-state choice).
- proc_done outside EXEC is ignored.
- run held high continuously restarts only from IDLE/HALT. It is ignored while busy.
- last_addr=0: exactly one instruction executes.
- pc never exceeds last_addr. There is no wrap.
- prog_we in the same cycle as run in IDLE: the write completes at that edge, so the subsequent FETCH reads the new word.
- Reset asserted mid-EXEC: start=0 immediately (async); memory contents are retained.

Optional Feature:
SEQ_TIMEOUT_EN.
- Defined: a counter clears on entering EXEC and increments each EXEC cycle without proc_done. If it reaches TIMEOUT_CYCLES, error<=1 and the FSM goes to HALT with start=0; the instruction is not counted. error stays set until the next accepted run or reset.
- Undefined: there is no counter, error is tied to 0, and EXEC waits indefinitely for proc_done.

Test Plan:
- Load 0x123, 0x456, 0x789 at addresses 0..2, last_addr=2, pulse run. Processor model returns done 3 cycles after start rises. Expect start high 2 clocks after run, machine_code sequence 0x123/0x456/0x789, one low start cycle between instructions, then halted=1, pc=2, instr_count=3.
- last_addr=0 with word 0xE07 at address 0. Expect a single EXEC, then HALT with instr_count=1 and start=0.
- Assert abort during EXEC of the second instruction. Expect start=0 next cycle, halted=1, pc=1, instr_count=1. Then run again: restart at pc=0 with instr_count cleared.
- prog_we to address 1 during EXEC. Expect memory unchanged: a second run presents the original word at address 1.
- proc_done and abort asserted together in EXEC of instruction 0. Expect instr_count=1, halted=1.
- With SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, proc_done held low: expect error=1 and HALT after 8 EXEC cycles with instr_count=0. A subsequent run clears error.
